// File: rtl/conv_read_sched.sv
// conv_read_sched: sliding-window read-address scheduler for the 1-D conv PE.
// Walks IF and filter scratchpads one tap per cycle, window after window.
module conv_read_sched #(
    parameter int FILT_ADDR_LEN = 4,
    parameter int IF_ADDR_LEN   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [FILT_ADDR_LEN-1:0] filt_len,
    input  logic [IF_ADDR_LEN-1:0]   if_len,
    input  logic [IF_ADDR_LEN-1:0]   stride,
    input  logic                     stall,
    output logic [IF_ADDR_LEN-1:0]   if_raddr,
    output logic [FILT_ADDR_LEN-1:0] filt_raddr,
    output logic                     rd_en,
    output logic                     mac_first,
    output logic                     psum_done,
    output logic                     stride_count_flag,
    output logic                     full_done,
    output logic                     busy,
    output logic [IF_ADDR_LEN-1:0]   win_count
);

    // Two extra bits keep base+stride+filt_len from wrapping in the fit test.
    localparam int FW = IF_ADDR_LEN + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [IF_ADDR_LEN-1:0]   base_q, base_d;
    logic [IF_ADDR_LEN-1:0]   wc_q, wc_d;
    logic [IF_ADDR_LEN-1:0]   ilen_q, stride_q;
    logic [FILT_ADDR_LEN-1:0] tap_q, tap_d;
    logic [FILT_ADDR_LEN-1:0] flen_q;

    logic [FILT_ADDR_LEN-1:0] flen_n;
    logic [IF_ADDR_LEN-1:0]   stride_n;
    logic                     cfg_bad;
    logic                     last_tap;
    logic                     fits;

    // Zero lengths/strides are treated as 1 so every row makes progress.
    assign flen_n   = (filt_len == '0) ? FILT_ADDR_LEN'(1) : filt_len;
    assign stride_n = (stride == '0) ? IF_ADDR_LEN'(1) : stride;
    assign cfg_bad  = FW'(flen_n) > FW'(if_len);
    assign last_tap = tap_q == (flen_q - FILT_ADDR_LEN'(1));
    assign fits     = (FW'(base_q) + FW'(stride_q) + FW'(flen_q))
                      <= FW'(ilen_q);

    // Next-state, counter updates and per-cycle read strobes.
    always_comb begin
        state_d           = state_q;
        base_d            = base_q;
        tap_d             = tap_q;
        wc_d              = wc_q;
        if_raddr          = '0;
        filt_raddr        = '0;
        rd_en             = 1'b0;
        mac_first         = 1'b0;
        psum_done         = 1'b0;
        stride_count_flag = 1'b0;
        full_done         = 1'b0;
        busy              = 1'b0;
        unique case (state_q)
            IDLE: begin
            end
            RUN: begin
                busy       = 1'b1;
                if_raddr   = base_q + IF_ADDR_LEN'(tap_q);
                filt_raddr = tap_q;
                if (!stall) begin
                    rd_en     = 1'b1;
                    mac_first = tap_q == '0;
                    psum_done = last_tap;
                    if (!last_tap) begin
                        tap_d = tap_q + FILT_ADDR_LEN'(1);
                    end else if (fits) begin
                        stride_count_flag = ~start;
                        base_d = base_q + stride_q;
                        tap_d  = '0;
                        wc_d   = wc_q + IF_ADDR_LEN'(1);
                    end else begin
                        wc_d    = wc_q + IF_ADDR_LEN'(1);
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                full_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A start always wins: it aborts any row in flight and restarts.
        if (start) begin
            base_d  = '0;
            tap_d   = '0;
            wc_d    = '0;
            state_d = cfg_bad ? DONE : RUN;
        end
    end

    assign win_count = wc_q;

    // State, counters and the configuration latched on start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            tap_q    <= '0;
            wc_q     <= '0;
            flen_q   <= '0;
            ilen_q   <= '0;
            stride_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            tap_q   <= tap_d;
            wc_q    <= wc_d;
            if (start) begin
                flen_q   <= flen_n;
                ilen_q   <= if_len;
                stride_q <= stride_n;
            end
        end
    end

endmodule

// File: tb/tb_conv_read_sched.sv
// tb_conv_read_sched: table vectors, hand sequences and a queue-based
// reference model with random stalls for conv_read_sched.
module tb_conv_read_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] filt_len = '0;
    logic [4:0] if_len = '0;
    logic [4:0] stride = '0;
    logic       stall = 1'b0;
    logic [4:0] if_raddr;
    logic [3:0] filt_raddr;
    logic       rd_en, mac_first, psum_done, stride_count_flag;
    logic       full_done, busy;
    logic [4:0] win_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic s, st, rd;
        int   ia, fa;
        logic mf, pd, sc, fd, b;
        int   wc;
    } vec_t;

    typedef struct {
        int ia, fa;
        bit mf, pd, sc;
        int wc;
    } exp_t;

    conv_read_sched #(.FILT_ADDR_LEN(4), .IF_ADDR_LEN(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .filt_len(filt_len), .if_len(if_len), .stride(stride),
        .stall(stall), .if_raddr(if_raddr), .filt_raddr(filt_raddr),
        .rd_en(rd_en), .mac_first(mac_first), .psum_done(psum_done),
        .stride_count_flag(stride_count_flag), .full_done(full_done),
        .busy(busy), .win_count(win_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t v(input logic s, st, rd, input int ia, fa,
                               input logic mf, pd, sc, fd, b,
                               input int wc);
        vec_t r;
        r.s = s; r.st = st; r.rd = rd; r.ia = ia; r.fa = fa;
        r.mf = mf; r.pd = pd; r.sc = sc; r.fd = fd; r.b = b;
        r.wc = wc;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        stall = 1'b0;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        chk("reset rd_en", rd_en, 0);
        chk("reset busy", busy, 0);
        chk("reset full_done", full_done, 0);
        chk("reset win_count", win_count, 0);
        rst = 1'b0;
    endtask

    task automatic set_cfg(input int fl, il, st);
        filt_len = 4'(fl);
        if_len   = 5'(il);
        stride   = 5'(st);
    endtask

    task automatic run_table(input string tag, input vec_t tbl[$]);
        foreach (tbl[i]) begin
            start = tbl[i].s;
            stall = tbl[i].st;
            @(negedge clk);
            chk($sformatf("%s c%0d rd_en", tag, i), rd_en, tbl[i].rd);
            chk($sformatf("%s c%0d if_raddr", tag, i), if_raddr, tbl[i].ia);
            chk($sformatf("%s c%0d filt_raddr", tag, i), filt_raddr,
                tbl[i].fa);
            chk($sformatf("%s c%0d mac_first", tag, i), mac_first,
                tbl[i].mf);
            chk($sformatf("%s c%0d psum_done", tag, i), psum_done,
                tbl[i].pd);
            chk($sformatf("%s c%0d scf", tag, i), stride_count_flag,
                tbl[i].sc);
            chk($sformatf("%s c%0d full_done", tag, i), full_done,
                tbl[i].fd);
            chk($sformatf("%s c%0d busy", tag, i), busy, tbl[i].b);
            chk($sformatf("%s c%0d win_count", tag, i), win_count,
                tbl[i].wc);
            next_cycle();
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    // Issues start with the given config in the current cycle, then
    // checks every following cycle against a list of expected reads.
    task automatic run_model(input string tag, input int fl, il, st,
                             input int stall_pct);
        exp_t q[$];
        exp_t e;
        int fle, ste, wins, idx, cyc;
        fle = (fl == 0) ? 1 : fl;
        ste = (st == 0) ? 1 : st;
        wins = (fle > il) ? 0 : (il - fle) / ste + 1;
        for (int w = 0; w < wins; w++) begin
            for (int t = 0; t < fle; t++) begin
                e.ia = w * ste + t;
                e.fa = t;
                e.mf = (t == 0);
                e.pd = (t == fle - 1);
                e.sc = (t == fle - 1) && (w < wins - 1);
                e.wc = w;
                q.push_back(e);
            end
        end
        set_cfg(fl, il, st);
        start = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        chk({tag, " start full_done"}, full_done, 0);
        next_cycle();
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < q.size() && cyc < 5000) begin
            stall = ($urandom_range(0, 99) < stall_pct);
            @(negedge clk);
            e = q[idx];
            chk({tag, " if_raddr"}, if_raddr, e.ia);
            chk({tag, " filt_raddr"}, filt_raddr, e.fa);
            chk({tag, " rd_en"}, rd_en, !stall);
            chk({tag, " mac_first"}, mac_first, !stall && e.mf);
            chk({tag, " psum_done"}, psum_done, !stall && e.pd);
            chk({tag, " scf"}, stride_count_flag, !stall && e.sc);
            chk({tag, " run full_done"}, full_done, 0);
            chk({tag, " run busy"}, busy, 1);
            chk({tag, " run win_count"}, win_count, e.wc);
            next_cycle();
            if (!stall) idx++;
            cyc++;
        end
        if (cyc >= 5000) chk({tag, " read budget"}, idx, q.size());
        stall = 1'b0;
        @(negedge clk);
        chk({tag, " done full_done"}, full_done, 1);
        chk({tag, " done busy"}, busy, 1);
        chk({tag, " done rd_en"}, rd_en, 0);
        chk({tag, " done win_count"}, win_count, wins);
        next_cycle();
        @(negedge clk);
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " idle full_done"}, full_done, 0);
        chk({tag, " idle win_count"}, win_count, wins);
        next_cycle();
    endtask

    initial begin
        vec_t t1[$];
        vec_t t2[$];
        int ia_exp[4];
        next_cycle();

        // Scenario 1: filt_len=3, if_len=7, stride=2, no stall.
        t1.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        t1.push_back(v(0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0));
        t1.push_back(v(0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0));
        t1.push_back(v(0, 0, 1, 2, 2, 0, 1, 1, 0, 1, 0));
        t1.push_back(v(0, 0, 1, 2, 0, 1, 0, 0, 0, 1, 1));
        t1.push_back(v(0, 0, 1, 3, 1, 0, 0, 0, 0, 1, 1));
        t1.push_back(v(0, 0, 1, 4, 2, 0, 1, 1, 0, 1, 1));
        t1.push_back(v(0, 0, 1, 4, 0, 1, 0, 0, 0, 1, 2));
        t1.push_back(v(0, 0, 1, 5, 1, 0, 0, 0, 0, 1, 2));
        t1.push_back(v(0, 0, 1, 6, 2, 0, 1, 0, 0, 1, 2));
        t1.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3));
        t1.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        do_reset();
        set_cfg(3, 7, 2);
        run_table("s1", t1);

        // Same row with stall high in cycles 2-3.
        t2.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        t2.push_back(v(0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0));
        t2.push_back(v(0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0));
        t2.push_back(v(0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0));
        t2.push_back(v(0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0));
        t2.push_back(v(0, 0, 1, 2, 2, 0, 1, 1, 0, 1, 0));
        t2.push_back(v(0, 0, 1, 2, 0, 1, 0, 0, 0, 1, 1));
        t2.push_back(v(0, 0, 1, 3, 1, 0, 0, 0, 0, 1, 1));
        t2.push_back(v(0, 0, 1, 4, 2, 0, 1, 1, 0, 1, 1));
        t2.push_back(v(0, 0, 1, 4, 0, 1, 0, 0, 0, 1, 2));
        t2.push_back(v(0, 0, 1, 5, 1, 0, 0, 0, 0, 1, 2));
        t2.push_back(v(0, 0, 1, 6, 2, 0, 1, 0, 0, 1, 2));
        t2.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3));
        t2.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        do_reset();
        set_cfg(3, 7, 2);
        run_table("stall", t2);

        // Single-tap filter, unit stride.
        do_reset();
        run_model("s2", 1, 4, 1, 0);

        // Degenerate configurations.
        run_model("degen", 5, 3, 1, 0);
        run_model("zero", 0, 2, 0, 0);
        run_model("exact", 15, 15, 31, 0);

        // Restart in cycle 5 of scenario 1 with a new config.
        do_reset();
        ia_exp[0] = 0; ia_exp[1] = 1; ia_exp[2] = 2; ia_exp[3] = 2;
        set_cfg(3, 7, 2);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("restart pre c%0d if_raddr", c + 1), if_raddr,
                ia_exp[c]);
            next_cycle();
        end
        run_model("restart", 2, 4, 2, 0);

        // Asynchronous reset mid-row, then a clean rerun.
        do_reset();
        set_cfg(3, 7, 2);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("prerst win_count", win_count, 1);
        next_cycle();
        rst = 1'b1;
        #1;
        chk("arst rd_en", rd_en, 0);
        chk("arst busy", busy, 0);
        chk("arst if_raddr", if_raddr, 0);
        chk("arst mac_first", mac_first, 0);
        chk("arst win_count", win_count, 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        run_model("after_rst", 3, 7, 2, 0);

        // Random configurations with random stalls.
        for (int i = 0; i < 40; i++) begin
            run_model($sformatf("rnd%0d", i), $urandom_range(0, 15),
                      $urandom_range(0, 31), $urandom_range(0, 31), 30);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_read_sched.md
Name: conv_read_sched

Overview:
Read-address scheduler for the 1-D convolution PE. The top-level design controller pulses start_rd_gen into this block's start, along with the layer configuration. The block then walks the IF scratchpad and filter scratchpad in sliding-window order, one tap per cycle. It emits psum_done, stride_count_flag and full_done back to the design controller, and accumulator control to the MAC.

Parameters:
FILT_ADDR_LEN, 4, width of filter scratchpad address and of filt_len
IF_ADDR_LEN, 5, width of IF scratchpad address, if_len, stride and win_count

Ports:
clk  input  1  clock
rst  input  1  reset
start  input  1  one-cycle pulse; latch config and begin (or restart) a row
filt_len  input  FILT_ADDR_LEN  number of filter taps, sampled on start
if_len  input  IF_ADDR_LEN  number of valid IF elements, sampled on start
stride  input  IF_ADDR_LEN  window step, sampled on start
stall  input  1  hold all counters; suppress rd_en and pulses
if_raddr  output  IF_ADDR_LEN  IF scratchpad read address (base+tap)
filt_raddr  output  FILT_ADDR_LEN  filter scratchpad read address (tap)
rd_en  output  1  read strobe for both scratchpads
mac_first  output  1  current read is tap 0 of a window (MAC loads instead of accumulates)
psum_done  output  1  current read is the last tap of a window
stride_count_flag  output  1  window complete and another window follows
full_done  output  1  one-cycle pulse; all windows of the row complete
busy  output  1  high in RUN and DONE
win_count  output  IF_ADDR_LEN  windows completed since last start

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. rst forces IDLE and clears base, tap, win_count and latched config. All outputs are 0 during and after reset.
- Config normalisation at latch: filt_len==0 becomes 1; stride==0 becomes 1.
- Window-fit test: base+stride+filt_len <= if_len. Evaluate in IF_ADDR_LEN+2 bits so no wrap occurs.
- States: IDLE, RUN, DONE.
- IDLE:
  - All outputs 0 except win_count, which holds.
  - start at edge k: latch config, base=0, tap=0, win_count=0.
  - If latched filt_len > if_len, go to DONE. Otherwise go to RUN.
- RUN:
  - if_raddr=base+tap and filt_raddr=tap are combinational from the counters, valid every cycle.
  - rd_en = ~stall. First read occurs in the cycle after start is sampled.
  - mac_first = ~stall & (tap==0).
  - psum_done = ~stall & (tap==filt_len-1).
  - Non-stalled cycle, tap<filt_len-1: tap += 1.
  - Non-stalled cycle, last tap, next window fits: stride_count_flag=1, base += stride, tap=0, win_count += 1.
  - Non-stalled cycle, last tap, next window does not fit: win_count += 1, go to DONE.
  - stall=1: counters and state hold; rd_en, mac_first, psum_done and stride_count_flag are 0. Addresses hold their values.
- DONE: full_done=1 and busy=1 for exactly one cycle, then IDLE.
- start in RUN or DONE: treated as an immediate restart. Relatch config, base=0, tap=0, win_count=0, go to RUN (or to DONE if filt_len > if_len). No full_done is emitted for the aborted row. start has priority over stall and over the last-tap transition.
- Throughput: filt_len cycles per window, no bubbles between windows. Total non-stalled RUN cycles = filt_len * windows, where windows = floor((if_len-filt_len)/stride)+1.
- rst mid-row: immediate return to IDLE; no pulse outputs.

Test Plan:
- filt_len=3, if_len=7, stride=2, no stall, start at cycle 0:
  - rd_en in cycles 1-9; if_raddr 0,1,2,2,3,4,4,5,6; filt_raddr 0,1,2 repeating.
  - mac_first in cycles 1,4,7; psum_done in cycles 3,6,9; stride_count_flag in cycles 3,6.
  - full_done in cycle 10; win_count=3; busy low from cycle 11.
- filt_len=1, if_len=4, stride=1: rd_en in cycles 1-4 with if_raddr 0-3. mac_first and psum_done high every read cycle; stride_count_flag in cycles 1-3; full_done in cycle 5; win_count=4.
- Same config as scenario 1 with stall high in cycles 2-3:
  - Addresses hold at if_raddr=1 in cycles 2-3, rd_en=0 in those cycles.
  - Read sequence is unchanged but shifted by 2 cycles; full_done in cycle 12.
- Restart: start again in cycle 5 of scenario 1 with filt_len=2, if_len=4, stride=2. No full_done for the first row; if_raddr 0,1,2,3 in cycles 6-9; full_done in cycle 10; win_count=2.
- Degenerate config: filt_len=5, if_len=3 -> no rd_en; full_done in cycle 1; win_count=0. Also filt_len=0, stride=0, if_len=2 behaves as filt_len=1, stride=1: 2 windows.
- rst asserted asynchronously in cycle 4 of scenario 1 -> all outputs 0 immediately and win_count=0. After release, a new start runs scenario 1 cleanly.
